setting_reg: RTL and testbench

SETTING_REG -- requirements
Module: setting_reg

---
 rtl/setting_reg_pkg.sv | 18 +
 rtl/setting_reg.sv | 53 +++++
 tb/tb_setting_reg.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/setting_reg_pkg.sv
// setting_reg_pkg
//   Settings-bus constants shared by every register that sits on the bus.
//   SB_ADDR_W : write address width
//   SB_DATA_W : write data width
//   sb_hit()  : address/strobe qualification used by each register

package setting_reg_pkg;

  localparam int SB_ADDR_W = 8;
  localparam int SB_DATA_W = 32;

  // A write reaches a register only when the strobe is up and the address matches.
  function automatic logic sb_hit(input logic strobe, input logic [SB_ADDR_W-1:0] addr,
                                  input logic [SB_ADDR_W-1:0] my_addr);
    return strobe && (addr == my_addr);
  endfunction

endpackage

// File: rtl/setting_reg.sv
// setting_reg
//   One settings-bus register. A write whose address matches my_addr loads
//   the low `width` bits of the bus data into out on that clk edge, and
//   changed pulses high for the following cycle. Several instances may share
//   an address; each latches the same write on its own.
//
// Parameters
//   my_addr  : bus address this register answers to
//   width    : stored width, 1..32
//   at_reset : value held in out while rst is low
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous reset, active low
//   strobe  : bus write strobe (one cycle)
//   addr    : bus write address
//   in      : bus write data (bits above width are dropped)
//   out     : register contents
//   changed : one-cycle pulse, out was written on the previous edge

module setting_reg
  import setting_reg_pkg::*;
#(
  parameter logic [SB_ADDR_W-1:0] my_addr  = '0,
  parameter int                   width    = 32,
  parameter logic [SB_DATA_W-1:0] at_reset = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 strobe,
  input  logic [SB_ADDR_W-1:0] addr,
  input  logic [SB_DATA_W-1:0] in,
  output logic [width-1:0]     out,
  output logic                 changed
);

  logic hit;

  assign hit = sb_hit(strobe, addr, my_addr);

  // Both outputs come straight from flops, so nothing on the bus reaches
  // out or changed without a clock edge. changed follows every hit, even
  // one that rewrites the current value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out     <= at_reset[width-1:0];
      changed <= 1'b0;
    end else begin
      changed <= hit;
      if (hit) out <= in[width-1:0];
    end
  end

endmodule

// File: tb/tb_setting_reg.sv
// tb_setting_reg
//   Three registers on one bus: A (addr 5, 32 bit), B (addr 3, 8 bit) and
//   C (addr 5, 16 bit, sharing A's address). Each bus cycle pushes the
//   model's next-cycle expectation; it is popped and compared after the edge.

module tb_setting_reg;
  import setting_reg_pkg::*;

  localparam logic [31:0] A_RST = 32'h1234_5678;
  localparam logic [31:0] B_RST = 32'h0000_00A5;
  localparam logic [31:0] C_RST = 32'h0000_BEEF;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst = 1'b1;
  logic        strobe = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [31:0] in = 32'h0;

  logic [31:0] a_out;
  logic [7:0]  b_out;
  logic [15:0] c_out;
  logic        a_chg, b_chg, c_chg;

  typedef struct {
    logic [31:0] a_out; logic a_chg;
    logic [31:0] b_out; logic b_chg;
    logic [31:0] c_out; logic c_chg;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        m;
  int          tests = 0;
  int          fails = 0;

  setting_reg #(.my_addr(8'd5), .width(32), .at_reset(A_RST)) dut_a (
    .clk(clk), .rst(rst), .strobe(strobe), .addr(addr), .in(in), .out(a_out), .changed(a_chg));
  setting_reg #(.my_addr(8'd3), .width(8), .at_reset(B_RST)) dut_b (
    .clk(clk), .rst(rst), .strobe(strobe), .addr(addr), .in(in), .out(b_out), .changed(b_chg));
  setting_reg #(.my_addr(8'd5), .width(16), .at_reset(C_RST)) dut_c (
    .clk(clk), .rst(rst), .strobe(strobe), .addr(addr), .in(in), .out(c_out), .changed(c_chg));

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag);
    m.tag = tag;
    sb.push_back(m);
  endtask

  task automatic pop_cmp();
    exp_t e;
    tests++;
    assert (sb.size() > 0) else begin
      fails++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb.size() > 0) begin
      tests--;
      e = sb.pop_front();
      chk({e.tag, "/a_out"}, a_out, e.a_out);
      chk({e.tag, "/a_chg"}, {31'b0, a_chg}, {31'b0, e.a_chg});
      chk({e.tag, "/b_out"}, {24'b0, b_out}, e.b_out);
      chk({e.tag, "/b_chg"}, {31'b0, b_chg}, {31'b0, e.b_chg});
      chk({e.tag, "/c_out"}, {16'b0, c_out}, e.c_out);
      chk({e.tag, "/c_chg"}, {31'b0, c_chg}, {31'b0, e.c_chg});
    end
  endtask

  task automatic model_reset();
    m.a_out = A_RST;        m.a_chg = 1'b0;
    m.b_out = B_RST & 32'hFF; m.b_chg = 1'b0;
    m.c_out = C_RST & 32'hFFFF; m.c_chg = 1'b0;
  endtask

  // Drive one bus cycle between edges, predict the post-edge state, check it.
  task automatic cyc(input logic s, input logic [7:0] a, input logic [31:0] d, input string tag);
    @(negedge clk);
    strobe = s; addr = a; in = d;
    m.a_chg = s && (a == 8'd5); if (m.a_chg) m.a_out = d;
    m.b_chg = s && (a == 8'd3); if (m.b_chg) m.b_out = {24'b0, d[7:0]};
    m.c_chg = s && (a == 8'd5); if (m.c_chg) m.c_out = {16'b0, d[15:0]};
    push(tag);
    @(posedge clk);
    #1;
    pop_cmp();
  endtask

  initial begin
    // Reset with the clock stopped: values must appear with no edge at all.
    #2 rst = 1'b0;
    #1;
    model_reset();
    push("reset_noclk");
    pop_cmp();

    clk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // First hit right after release loads with no warm-up.
    cyc(1'b1, 8'd5, 32'hDEAD_BEEF, "hit");
    cyc(1'b0, 8'd5, 32'h0,         "hit_after");
    // Misses: wrong address, then right address without strobe.
    cyc(1'b1, 8'd6, 32'h1,         "miss_addr");
    cyc(1'b0, 8'd5, 32'h2,         "miss_strobe");
    // Truncation on the 8-bit register.
    cyc(1'b1, 8'd3, 32'hABCD_1234, "trunc");
    cyc(1'b0, 8'd0, 32'h0,         "trunc_after");
    // Same value and back-to-back writes.
    cyc(1'b1, 8'd5, 32'h7,         "b2b_0");
    cyc(1'b1, 8'd5, 32'h7,         "b2b_1");
    cyc(1'b1, 8'd5, 32'h9,         "b2b_2");
    cyc(1'b0, 8'd5, 32'h0,         "b2b_idle");
    cyc(1'b1, 8'd5, 32'h55,        "pre_rst");
    cyc(1'b0, 8'd0, 32'h0,         "pre_rst_idle");

    // Reset dropped between edges while a hit is on the bus.
    @(negedge clk);
    strobe = 1'b1; addr = 8'd5; in = 32'hAA;
    #2 rst = 1'b0;
    #1;
    model_reset();
    push("rst_async");
    pop_cmp();
    @(posedge clk);
    #1;
    push("rst_hit_lost");
    pop_cmp();
    @(negedge clk);
    rst = 1'b1;
    strobe = 1'b0;
    cyc(1'b0, 8'd5, 32'h0,         "rst_released");
    cyc(1'b1, 8'd5, 32'h1357_9BDF, "post_rst_hit");
    cyc(1'b1, 8'd3, 32'hFFFF_FF00, "post_rst_b");
    cyc(1'b0, 8'd3, 32'h0,         "final_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
